// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// type, default memory depth and request legality helpers.
package lsu_pkg;

  localparam int unsigned LSU_MEM_WORDS = 1000;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } lsu_state_e;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  // Size lives in f3[1:0] for every legal code: 01 = half, 10 = word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (f3[1:0] == 2'b01 && addr_lo[0]) begin
      bad = 1'b1;
    end
    if (f3[1:0] == 2'b10 && addr_lo != 2'b00) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory
// word, and merges store bytes/halves into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
    half_sel = mem_word[{addr_lo[1], 4'b0000} +: 16];

    load_data = mem_word;
    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h000000, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0000, half_sel};
      default: load_data = mem_word;
    endcase

    merged_word = store_data;
    case (funct3)
      SB: begin
        merged_word = mem_word;
        merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      SH: begin
        merged_word = mem_word;
        merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, byte/half stores done as
// read-modify-write. Define LSU_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;

  logic        oob;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  always_comb assert (MEM_WORDS > 0);

  always_comb begin
`ifdef LSU_BOUNDS_CHECK_EN
    oob = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
`else
    oob = 1'b0;
`endif
    req_err = !funct3_legal(req_write, req_funct3)
            || misaligned(req_funct3, req_addr[1:0])
            || oob;
  end

  lsu_lane_align u_lane_align (
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .mem_word    (word_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    word_d   = word_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          write_d  = req_write;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && req_funct3 == SW) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        word_d  = mem_rdata;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  // Outputs decode straight from flops so an asynchronous reset clears them at once.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_read  = (state_q == RD);
    mem_write = (state_q == WR);
    mem_addr  = (mem_read || mem_write) ? {2'b00, addr_q[31:2]} : '0;
    mem_wdata = mem_write ? merged_word : '0;
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !write_q) ? load_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-array memory and a
// transaction-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[10:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[10:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]     = val;
    ref_mem[idx] = val;
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic run_txn(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    logic        err;
    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] idx, old, nw, exp_data, b;
    int          lat, nrd, nwr, t;
    logic        addr_bad, both;
    logic [31:0] got_rd;
    logic        got_err;

    idx = {2'b00, a[31:2]};
    if (w) err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) err = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if (idx >= 32'd1000) err = 1'b1;
`endif
    old      = ref_mem[idx[10:0]];
    nw       = old;
    exp_data = 32'h0;
    if (err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!w) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        b = (old >> (8 * a[1:0])) & 32'hFF;
        if (f3 == 3'd0 && b >= 32'd128) b = b | 32'hFFFF_FF00;
        exp_data = b;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        b = (old >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'd1 && b >= 32'h8000) b = b | 32'hFFFF_0000;
        exp_data = b;
      end else begin
        exp_data = old;
      end
    end else if (f3 == 3'd2) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      nw = wd;
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
      if (f3 == 3'd0)
        nw = (old & ~(32'hFF << (8 * a[1:0]))) | ((wd & 32'hFF) << (8 * a[1:0]));
      else
        nw = (old & ~(32'hFFFF << (16 * a[1]))) | ((wd & 32'hFFFF) << (16 * a[1]));
    end

    t = 0;
    while (!req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_before_req", {31'b0, req_ready}, 32'd1);

    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    lat = 0; nrd = 0; nwr = 0; addr_bad = 0; both = 0;
    got_rd = 32'h0; got_err = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if (mem_read && mem_write) both = 1'b1;
      if ((mem_read || mem_write) && mem_addr !== idx) addr_bad = 1'b1;
      if (rsp_valid) begin
        lat     = k;
        got_rd  = rsp_rdata;
        got_err = rsp_err;
      end
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", {31'b0, got_err}, {31'b0, err});
    chk("rsp_rdata", got_rd, exp_data);
    chk("mem_read_cycles", 32'(nrd), 32'(exp_rd));
    chk("mem_write_cycles", 32'(nwr), 32'(exp_wr));
    chk("mem_addr_index", {31'b0, addr_bad}, 32'd0);
    chk("read_write_overlap", {31'b0, both}, 32'd0);
    if (!err && w) ref_mem[idx[10:0]] = nw;
    chk("mem_word_after", mem[idx[10:0]], ref_mem[idx[10:0]]);

    @(negedge clk);
    chk("rsp_valid_one_cycle", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_after_resp", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"},   {31'b0, rsp_err},   32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,          32'd0);
    chk({tag, "_mem_read"},  {31'b0, mem_read},  32'd0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"},  mem_addr,           32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        saw_rsp;
    logic [2:0]  legal_ld [5];
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    for (int i = 0; i < 2048; i++) preload(i, $urandom);

    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    // SW then LW round trip
    run_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    run_txn(1'b0, 3'd2, 32'h10, 32'h0);
    chk("sw_lw_word4", mem[4], 32'hDEADBEEF);

    // SB read-modify-write into the top byte lane
    preload(4, 32'h11223344);
    run_txn(1'b1, 3'd0, 32'h13, 32'h000000AA);
    chk("sb_merge_word4", mem[4], 32'hAA223344);

    // Sign / zero extension
    preload(4, 32'h8000F0FF);
    run_txn(1'b0, 3'd0, 32'h10, 32'h0);
    run_txn(1'b0, 3'd4, 32'h10, 32'h0);
    run_txn(1'b0, 3'd1, 32'h12, 32'h0);
    run_txn(1'b0, 3'd5, 32'h12, 32'h0);

    // Misalignment, illegal codes, out-of-range index
    run_txn(1'b0, 3'd2, 32'h12, 32'h0);
    run_txn(1'b1, 3'd1, 32'h11, 32'h12345678);
    run_txn(1'b0, 3'd3, 32'h20, 32'h0);
    run_txn(1'b1, 3'd4, 32'h20, 32'h5A5A5A5A);
    run_txn(1'b0, 3'd2, 32'd4000, 32'h0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(9) == 0) f3 = 3'($urandom);
      else if ($urandom_range(1) == 1) f3 = 3'($urandom_range(2));
      else f3 = legal_ld[$urandom_range(4)];
      a = {$urandom_range(31), 2'($urandom)};
      a = {a[29:0], 2'b00} | 32'(a[1:0]);
      a = (32'($urandom_range(31)) << 2) | 32'($urandom_range(3));
      run_txn(1'($urandom), f3, a, $urandom);
    end

    // Reset during the write phase of a byte store
    preload(4, 32'h11223344);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h13;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_phase", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    chk("rmw_wr_phase", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midwr_reset");
    @(negedge clk);
    chk("midwr_mem_unchanged", mem[4], 32'h11223344);
    rst_n = 1'b1;
    #1;
    chk("midwr_req_ready", {31'b0, req_ready}, 32'd1);
    saw_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("midwr_no_rsp", {31'b0, saw_rsp}, 32'd0);
    chk("midwr_mem_final", mem[4], 32'h11223344);

    run_txn(1'b0, 3'd2, 32'h10, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1);
  end

endmodule
